// File: rtl/ex_forward_unit.sv
// EX-stage operand forwarding unit.
// Detects RAW hazards against the instruction in ID and registers one forward
// select per source operand into the ID/EX boundary. In EX the registered
// selects steer each operand between the regfile value, the EX/MEM ALU result,
// the MEM/WB write-back value and a local copy of the last retired WB value.
// Also raises the load-use stall and keeps a saturating count of stall cycles.
module ex_forward_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inIdValid,
  input  logic [NUM_OPS*REG_AW-1:0]   inIdSrcAddr,
  input  logic [NUM_OPS-1:0]          inIdSrcUsed,
  input  logic                        inExRegWrite,
  input  logic                        inExMemRead,
  input  logic [REG_AW-1:0]           inExRegDst,
  input  logic                        inMemRegWrite,
  input  logic [REG_AW-1:0]           inMemRegDst,
  input  logic                        inWbRegWrite,
  input  logic [REG_AW-1:0]           inWbRegDst,
  input  logic                        inFreeze,
  input  logic                        inFlush,
  input  logic [NUM_OPS*DATA_W-1:0]   inDataOps,
  input  logic [DATA_W-1:0]           inOutAlu,
  input  logic [DATA_W-1:0]           inMuxWb,
  output logic [NUM_OPS*DATA_W-1:0]   outOps,
  output logic [2*NUM_OPS-1:0]        outForwardSel,
  output logic                        outStall,
  output logic [CNT_W-1:0]            outStallCnt
);

  localparam int unsigned SEL_W = 2 * NUM_OPS;

  // Forward select encodings
  localparam logic [1:0] SEL_RF   = 2'b00;  // regfile value latched in ID/EX
  localparam logic [1:0] SEL_WB   = 2'b01;  // MEM/WB write-back mux
  localparam logic [1:0] SEL_ALU  = 2'b10;  // EX/MEM ALU result
  localparam logic [1:0] SEL_HOLD = 2'b11;  // retired WB value held locally

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  logic [NUM_OPS-1:0] matchEx;
  logic [NUM_OPS-1:0] matchMem;
  logic [NUM_OPS-1:0] matchWb;
  logic [SEL_W-1:0]   nextSel;
  logic [SEL_W-1:0]   selReg;
  logic [DATA_W-1:0]  wbHold;
  logic [CNT_W-1:0]   stallCnt;
  logic               loadBubble;

  // Per-operand hazard detection, next-select priority and EX operand mux
  for (genvar g = 0; g < NUM_OPS; g++) begin : gOp
    logic [REG_AW-1:0] src;
    logic [1:0]        opSel;
    logic [DATA_W-1:0] opVal;

    assign src = inIdSrcAddr[g*REG_AW +: REG_AW];

    // A producer matches only if it really writes a non-zero register that
    // this operand actually reads; r0 never forwards.
    assign matchEx[g]  = inExRegWrite  && (inExRegDst  != REG_ZERO) &&
                         (inExRegDst  == src) && inIdSrcUsed[g];
    assign matchMem[g] = inMemRegWrite && (inMemRegDst != REG_ZERO) &&
                         (inMemRegDst == src) && inIdSrcUsed[g];
    assign matchWb[g]  = inWbRegWrite  && (inWbRegDst  != REG_ZERO) &&
                         (inWbRegDst  == src) && inIdSrcUsed[g];

    // Youngest producer wins: EX > MEM > WB > regfile
    always_comb begin
      opSel = SEL_RF;
      if (matchEx[g]) begin
        opSel = SEL_ALU;
      end else if (matchMem[g]) begin
        opSel = SEL_WB;
      end else if (matchWb[g]) begin
        opSel = SEL_HOLD;
      end
    end

    assign nextSel[2*g +: 2] = opSel;

    // EX operand mux driven by the registered select; every code is defined
    always_comb begin
      opVal = inDataOps[g*DATA_W +: DATA_W];
      case (selReg[2*g +: 2])
        SEL_RF:   opVal = inDataOps[g*DATA_W +: DATA_W];
        SEL_WB:   opVal = inMuxWb;
        SEL_ALU:  opVal = inOutAlu;
        SEL_HOLD: opVal = wbHold;
        default:  opVal = inDataOps[g*DATA_W +: DATA_W];
      endcase
    end

    assign outOps[g*DATA_W +: DATA_W] = opVal;
  end

  // Load-use: a load in EX feeding an operand of a valid ID instruction.
  // Deliberately not gated by reset or freeze.
  assign outStall = inIdValid && inExMemRead && (|matchEx);

  // A stalled or invalid ID slot enters EX as a bubble with all selects 00
  assign loadBubble = outStall || !inIdValid;

  // Forward select register into ID/EX: reset > flush > freeze > bubble > next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selReg <= '0;
    end else if (inFlush) begin
      selReg <= '0;
    end else if (inFreeze) begin
      selReg <= selReg;
    end else if (loadBubble) begin
      selReg <= '0;
    end else begin
      selReg <= nextSel;
    end
  end

  // Copy of the retiring WB value; covers a regfile without write-through
  // when the producer retires in the same cycle the consumer enters EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbHold <= '0;
    end else if (!inFreeze && inWbRegWrite) begin
      wbHold <= inMuxWb;
    end
  end

  // Saturating count of stall cycles that actually cost a pipeline cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (outStall && !inFreeze && (stallCnt != CNT_MAX)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign outForwardSel = selReg;
  assign outStallCnt   = stallCnt;

endmodule

// File: tb/tb_ex_forward_unit.sv
// Directed self-checking bench for ex_forward_unit.
// A second instance with a 2-bit counter shares the stimulus to exercise
// counter saturation.
`timescale 1ns/1ps
module tb_ex_forward_unit;

  logic        clk;
  logic        reset;
  logic        inIdValid;
  logic [9:0]  inIdSrcAddr;
  logic [1:0]  inIdSrcUsed;
  logic        inExRegWrite;
  logic        inExMemRead;
  logic [4:0]  inExRegDst;
  logic        inMemRegWrite;
  logic [4:0]  inMemRegDst;
  logic        inWbRegWrite;
  logic [4:0]  inWbRegDst;
  logic        inFreeze;
  logic        inFlush;
  logic [63:0] inDataOps;
  logic [31:0] inOutAlu;
  logic [31:0] inMuxWb;
  logic [63:0] outOps;
  logic [3:0]  outForwardSel;
  logic        outStall;
  logic [15:0] outStallCnt;
  logic [63:0] satOps;
  logic [3:0]  satForwardSel;
  logic        satStall;
  logic [1:0]  satStallCnt;

  int checks;
  int failures;

  ex_forward_unit dut (
    .clk(clk), .reset(reset), .inIdValid(inIdValid), .inIdSrcAddr(inIdSrcAddr),
    .inIdSrcUsed(inIdSrcUsed), .inExRegWrite(inExRegWrite), .inExMemRead(inExMemRead),
    .inExRegDst(inExRegDst), .inMemRegWrite(inMemRegWrite), .inMemRegDst(inMemRegDst),
    .inWbRegWrite(inWbRegWrite), .inWbRegDst(inWbRegDst), .inFreeze(inFreeze),
    .inFlush(inFlush), .inDataOps(inDataOps), .inOutAlu(inOutAlu), .inMuxWb(inMuxWb),
    .outOps(outOps), .outForwardSel(outForwardSel), .outStall(outStall),
    .outStallCnt(outStallCnt)
  );

  ex_forward_unit #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .inIdValid(inIdValid), .inIdSrcAddr(inIdSrcAddr),
    .inIdSrcUsed(inIdSrcUsed), .inExRegWrite(inExRegWrite), .inExMemRead(inExMemRead),
    .inExRegDst(inExRegDst), .inMemRegWrite(inMemRegWrite), .inMemRegDst(inMemRegDst),
    .inWbRegWrite(inWbRegWrite), .inWbRegDst(inWbRegDst), .inFreeze(inFreeze),
    .inFlush(inFlush), .inDataOps(inDataOps), .inOutAlu(inOutAlu), .inMuxWb(inMuxWb),
    .outOps(satOps), .outForwardSel(satForwardSel), .outStall(satStall),
    .outStallCnt(satStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    inIdValid     = 1'b0;
    inIdSrcAddr   = '0;
    inIdSrcUsed   = '0;
    inExRegWrite  = 1'b0;
    inExMemRead   = 1'b0;
    inExRegDst    = '0;
    inMemRegWrite = 1'b0;
    inMemRegDst   = '0;
    inWbRegWrite  = 1'b0;
    inWbRegDst    = '0;
    inFreeze      = 1'b0;
    inFlush       = 1'b0;
    inDataOps     = {32'h2222_2222, 32'h1111_1111};
    inOutAlu      = 32'hAAAA_AAAA;
    inMuxWb       = 32'hBBBB_BBBB;
  endtask

  task automatic test_reset();
    clearInputs();
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd0, 5'd3};
    inIdSrcUsed  = 2'b01;
    inExRegWrite = 1'b1;
    inExRegDst   = 5'd3;
    tick();
    checks++;
    if (outForwardSel !== 4'b0010) begin
      failures++;
      $display("FAIL reset_setup_sel got=%b exp=%b", outForwardSel, 4'b0010);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL reset_sel got=%b exp=%b", outForwardSel, 4'b0000);
    end
    checks++;
    if (outOps !== 64'h2222_2222_1111_1111) begin
      failures++;
      $display("FAIL reset_ops got=%h exp=%h", outOps, 64'h2222_2222_1111_1111);
    end
    checks++;
    if (outStallCnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", outStallCnt);
    end
    tick();
    reset = 1'b0;
    clearInputs();
    tick();
  endtask

  task automatic test_ex_forward();
    clearInputs();
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd0, 5'd3};
    inIdSrcUsed  = 2'b01;
    inExRegWrite = 1'b1;
    inExRegDst   = 5'd3;
    tick();
    clearInputs();
    inOutAlu = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (outForwardSel !== 4'b0010) begin
      failures++;
      $display("FAIL ex_sel got=%b exp=%b", outForwardSel, 4'b0010);
    end
    checks++;
    if (outOps !== 64'h2222_2222_DEAD_BEEF) begin
      failures++;
      $display("FAIL ex_ops got=%h exp=%h", outOps, 64'h2222_2222_DEAD_BEEF);
    end
  endtask

  task automatic test_priority();
    // EX and MEM both produce r3: EX wins
    clearInputs();
    inIdValid     = 1'b1;
    inIdSrcAddr   = {5'd0, 5'd3};
    inIdSrcUsed   = 2'b01;
    inExRegWrite  = 1'b1;
    inExRegDst    = 5'd3;
    inMemRegWrite = 1'b1;
    inMemRegDst   = 5'd3;
    tick();
    checks++;
    if (outForwardSel !== 4'b0010) begin
      failures++;
      $display("FAIL prio_ex_mem got=%b exp=%b", outForwardSel, 4'b0010);
    end
    // MEM only
    inExRegWrite = 1'b0;
    tick();
    inMemRegWrite = 1'b0;
    inMuxWb = 32'h0000_0077;
    #1;
    checks++;
    if (outForwardSel !== 4'b0001) begin
      failures++;
      $display("FAIL prio_mem_sel got=%b exp=%b", outForwardSel, 4'b0001);
    end
    checks++;
    if (outOps[31:0] !== 32'h0000_0077) begin
      failures++;
      $display("FAIL prio_mem_op got=%h exp=%h", outOps[31:0], 32'h0000_0077);
    end
    // WB only: hold reg captures 0x55, then WB bus moves on to 0x99
    inWbRegWrite = 1'b1;
    inWbRegDst   = 5'd3;
    inMuxWb      = 32'h0000_0055;
    tick();
    inWbRegWrite = 1'b0;
    inMuxWb      = 32'h0000_0099;
    #1;
    checks++;
    if (outForwardSel !== 4'b0011) begin
      failures++;
      $display("FAIL prio_wb_sel got=%b exp=%b", outForwardSel, 4'b0011);
    end
    checks++;
    if (outOps[31:0] !== 32'h0000_0055) begin
      failures++;
      $display("FAIL prio_wb_op got=%h exp=%h", outOps[31:0], 32'h0000_0055);
    end
  endtask

  task automatic test_load_use();
    clearInputs();
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd4, 5'd0};
    inIdSrcUsed  = 2'b10;
    inExRegWrite = 1'b1;
    inExMemRead  = 1'b1;
    inExRegDst   = 5'd4;
    #1;
    checks++;
    if (outStall !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall got=%b exp=1", outStall);
    end
    tick();
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL lu_bubble got=%b exp=%b", outForwardSel, 4'b0000);
    end
    checks++;
    if (outStallCnt !== 16'd1) begin
      failures++;
      $display("FAIL lu_cnt got=%0d exp=1", outStallCnt);
    end
    // Load has advanced to MEM
    inExRegWrite  = 1'b0;
    inExMemRead   = 1'b0;
    inExRegDst    = 5'd0;
    inMemRegWrite = 1'b1;
    inMemRegDst   = 5'd4;
    #1;
    checks++;
    if (outStall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_clear got=%b exp=0", outStall);
    end
    tick();
    inMuxWb = 32'h0000_4444;
    #1;
    checks++;
    if (outForwardSel !== 4'b0100) begin
      failures++;
      $display("FAIL lu_mem_sel got=%b exp=%b", outForwardSel, 4'b0100);
    end
    checks++;
    if (outOps[63:32] !== 32'h0000_4444) begin
      failures++;
      $display("FAIL lu_mem_op got=%h exp=%h", outOps[63:32], 32'h0000_4444);
    end
    checks++;
    if (outStallCnt !== 16'd1) begin
      failures++;
      $display("FAIL lu_cnt_hold got=%0d exp=1", outStallCnt);
    end
  endtask

  task automatic test_zero_unused_freeze();
    // r0 destination never forwards or stalls
    clearInputs();
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd0, 5'd0};
    inIdSrcUsed  = 2'b11;
    inExRegWrite = 1'b1;
    inExMemRead  = 1'b1;
    inExRegDst   = 5'd0;
    #1;
    checks++;
    if (outStall !== 1'b0) begin
      failures++;
      $display("FAIL r0_stall got=%b exp=0", outStall);
    end
    tick();
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL r0_sel got=%b exp=%b", outForwardSel, 4'b0000);
    end
    // Operand not used
    inIdSrcAddr = {5'd0, 5'd5};
    inIdSrcUsed = 2'b00;
    inExRegDst  = 5'd5;
    #1;
    checks++;
    if (outStall !== 1'b0) begin
      failures++;
      $display("FAIL unused_stall got=%b exp=0", outStall);
    end
    tick();
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL unused_sel got=%b exp=%b", outForwardSel, 4'b0000);
    end
    // Invalid ID slot enters EX as a bubble even with a match
    inIdValid   = 1'b0;
    inIdSrcUsed = 2'b01;
    inExMemRead = 1'b0;
    tick();
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL invalid_sel got=%b exp=%b", outForwardSel, 4'b0000);
    end
    // Establish sel0=10, then freeze with a pending load-use
    clearInputs();
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd7, 5'd6};
    inIdSrcUsed  = 2'b01;
    inExRegWrite = 1'b1;
    inExRegDst   = 5'd6;
    tick();
    inFreeze    = 1'b1;
    inIdSrcUsed = 2'b11;
    inExMemRead = 1'b1;
    inExRegDst  = 5'd7;
    #1;
    checks++;
    if (outStall !== 1'b1) begin
      failures++;
      $display("FAIL freeze_stall got=%b exp=1", outStall);
    end
    tick();
    checks++;
    if (outForwardSel !== 4'b0010) begin
      failures++;
      $display("FAIL freeze_sel got=%b exp=%b", outForwardSel, 4'b0010);
    end
    checks++;
    if (outStallCnt !== 16'd1) begin
      failures++;
      $display("FAIL freeze_cnt got=%0d exp=1", outStallCnt);
    end
  endtask

  task automatic test_flush_saturate();
    // Flush overrides freeze
    inFlush = 1'b1;
    tick();
    checks++;
    if (outForwardSel !== 4'b0000) begin
      failures++;
      $display("FAIL flush_sel got=%b exp=%b", outForwardSel, 4'b0000);
    end
    // Clear counters, then five back-to-back stall cycles
    clearInputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inIdValid    = 1'b1;
    inIdSrcAddr  = {5'd4, 5'd0};
    inIdSrcUsed  = 2'b10;
    inExRegWrite = 1'b1;
    inExMemRead  = 1'b1;
    inExRegDst   = 5'd4;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (satStallCnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_cnt got=%0d exp=3", satStallCnt);
    end
    checks++;
    if (outStallCnt !== 16'd5) begin
      failures++;
      $display("FAIL wide_cnt got=%0d exp=5", outStallCnt);
    end
    clearInputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_zero_unused_freeze();
    test_flush_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
